// File: rtl/sp_delay_line_ctrl.sv
// Single-port RAM delay-line controller for a FIR filter: clears the RAM, writes each
// accepted sample at wptr, then streams the newest TAPS samples newest-first to the MAC.
module sp_delay_line_ctrl #(
    parameter int unsigned AW   = 7,
    parameter int unsigned DW   = 18,
    parameter int unsigned TAPS = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic [AW-1:0] m_tap,
    output logic          m_last,
    output logic          ram_ce,
    output logic          ram_oce,
    output logic          ram_reset,
    output logic          ram_wre,
    output logic [AW-1:0] ram_ad,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);
    localparam logic [AW-1:0] LAST_TAP = AW'(TAPS - 1);

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DRAIN
    } state_t;

    state_t        state_q;
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] cnt_q;
    logic [DW-1:0] sample_q;
    logic          s_ready_q;
    logic          m_valid_q;
    logic [AW-1:0] m_tap_q;
    logic          m_last_q;
    logic          rd_issue;

    // A read is only issued when the output slot is free or being emptied this cycle,
    // so ram_dout (held while ce=0) always matches the beat on m_data.
    assign rd_issue = (state_q == ST_READ) && (!m_valid_q || m_ready);

    always_comb begin
        ram_ce  = 1'b0;
        ram_wre = 1'b0;
        ram_ad  = wptr_q - cnt_q;
        ram_din = '0;
        case (state_q)
            ST_CLEAR: begin
                ram_ce  = 1'b1;
                ram_wre = 1'b1;
                ram_ad  = cnt_q;
            end
            ST_WRITE: begin
                ram_ce  = 1'b1;
                ram_wre = 1'b1;
                ram_ad  = wptr_q;
                ram_din = sample_q;
            end
            ST_READ: ram_ce = rd_issue;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_CLEAR;
            wptr_q    <= '0;
            cnt_q     <= '0;
            sample_q  <= '0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_tap_q   <= '0;
            m_last_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        state_q   <= ST_IDLE;
                        s_ready_q <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (s_valid && s_ready_q) begin
                        sample_q  <= s_data;
                        s_ready_q <= 1'b0;
                        cnt_q     <= '0;
                        state_q   <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    cnt_q   <= '0;
                    state_q <= ST_READ;
                end
                ST_READ: begin
                    if (rd_issue) begin
                        m_valid_q <= 1'b1;
                        m_tap_q   <= cnt_q;
                        m_last_q  <= (cnt_q == LAST_TAP);
                        cnt_q     <= cnt_q + 1'b1;
                        if (cnt_q == LAST_TAP) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (m_valid_q && m_ready) begin
                        m_valid_q <= 1'b0;
                        m_tap_q   <= '0;
                        m_last_q  <= 1'b0;
                        wptr_q    <= wptr_q + 1'b1;
                        s_ready_q <= 1'b1;
                        state_q   <= ST_IDLE;
                    end
                end
                default: state_q <= ST_CLEAR;
            endcase
        end
    end

    assign s_ready   = s_ready_q;
    assign m_valid   = m_valid_q;
    assign m_tap     = m_tap_q;
    assign m_last    = m_last_q;
    assign m_data    = ram_dout;
    assign ram_oce   = 1'b1;
    assign ram_reset = reset;

endmodule

// File: tb/tb_sp_delay_line_ctrl.sv
// Directed bench for sp_delay_line_ctrl (TAPS=4) with a behavioural 128x18 single-port RAM.
module tb_sp_delay_line_ctrl;
    localparam int unsigned AW    = 7;
    localparam int unsigned DW    = 18;
    localparam int unsigned TAPS  = 4;
    localparam int unsigned DEPTH = 128;

    logic          clk = 1'b0;
    logic          reset;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [AW-1:0] m_tap;
    logic          m_last;
    logic          ram_ce;
    logic          ram_oce;
    logic          ram_reset;
    logic          ram_wre;
    logic [AW-1:0] ram_ad;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    always #5 clk = ~clk;

    sp_delay_line_ctrl #(.AW(AW), .DW(DW), .TAPS(TAPS)) dut (
        .clk       (clk),
        .reset     (reset),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_tap     (m_tap),
        .m_last    (m_last),
        .ram_ce    (ram_ce),
        .ram_oce   (ram_oce),
        .ram_reset (ram_reset),
        .ram_wre   (ram_wre),
        .ram_ad    (ram_ad),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    // RAM model; junk_fill preloads nonzero contents so the clear pass is observable.
    logic [DW-1:0] mem [DEPTH];
    logic          junk_fill;

    always @(posedge clk) begin
        if (junk_fill) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= DW'(32'h2A5A5 + i);
        end else if (ram_ce && ram_wre) begin
            mem[ram_ad] <= ram_din;
        end
        if (ram_reset) ram_dout <= '0;
        else if (ram_ce && !ram_wre) ram_dout <= mem[ram_ad];
    end

    typedef struct {
        logic [DW-1:0]            din;
        logic [TAPS-1:0][DW-1:0]  exp;
    } vec_t;

    vec_t          vecs [9];
    int unsigned   n_checks = 0;
    int unsigned   n_fail   = 0;
    logic [AW-1:0] wp       = '0;

    function automatic vec_t mkv(input logic [DW-1:0] d, input logic [DW-1:0] e0,
                                 input logic [DW-1:0] e1, input logic [DW-1:0] e2,
                                 input logic [DW-1:0] e3);
        vec_t v;
        v.din    = d;
        v.exp[0] = e0;
        v.exp[1] = e1;
        v.exp[2] = e2;
        v.exp[3] = e3;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_beat(input int t, input logic [DW-1:0] v);
        check("beat", {m_valid, m_tap, m_last, m_data}, {1'b1, 7'(t), (t == TAPS - 1), v});
    endtask

    // Entered on the first cycle with reset low; covers all DEPTH clear writes.
    task automatic check_clear();
        for (int i = 0; i < DEPTH; i++) begin
            check("clear_cycle", {s_ready, ram_ce, ram_wre, ram_ad, ram_din},
                  {1'b0, 1'b1, 1'b1, 7'(i), 18'h0});
            @(posedge clk); #1;
        end
        check("clear_done", {s_ready, ram_ce, m_valid}, 3'b100);
        wp = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {s_ready, m_valid, m_tap, m_last, ram_reset, ram_oce},
              {1'b0, 1'b0, 7'd0, 1'b0, 1'b1, 1'b1});
        @(posedge clk); #1;
        reset = 1'b0;
        check_clear();
    endtask

    // Returns one cycle after the accepting edge (the write cycle).
    task automatic push(input logic [DW-1:0] d);
        int unsigned n = 0;
        while (!s_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("s_ready_wait", {31'd0, s_ready}, 32'd1);
        s_valid = 1'b1;
        s_data  = d;
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_data  = DW'($urandom);
        check("write", {s_ready, ram_ce, ram_wre, ram_ad, ram_din}, {1'b0, 1'b1, 1'b1, wp, d});
    endtask

    task automatic burst(input logic [DW-1:0] d, input logic [TAPS-1:0][DW-1:0] e);
        push(d);
        for (int k = 0; k <= TAPS; k++) begin
            @(posedge clk); #1;
            if (k == 0) check("first_beat_latency", {m_valid, s_ready}, 2'b00);
            else check_beat(k - 1, e[k-1]);
            if (k < TAPS) check("read_issue", {ram_ce, ram_wre, ram_ad}, {1'b1, 1'b0, 7'(wp - k)});
            else check("drain_no_access", {31'd0, ram_ce}, 32'd0);
        end
        @(posedge clk); #1;
        check("ready_return", {s_ready, m_valid}, 2'b10);
        wp = wp + 1'b1;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [TAPS-1:0][DW-1:0] e;

        vecs[0] = mkv(1,  1,  0,  0,  0);
        vecs[1] = mkv(0,  0,  1,  0,  0);
        vecs[2] = mkv(0,  0,  0,  1,  0);
        vecs[3] = mkv(0,  0,  0,  0,  1);
        vecs[4] = mkv(10, 10, 0,  0,  0);
        vecs[5] = mkv(20, 20, 10, 0,  0);
        vecs[6] = mkv(30, 30, 20, 10, 0);
        vecs[7] = mkv(40, 40, 30, 20, 10);
        vecs[8] = mkv(50, 50, 40, 30, 20);

        reset     = 1'b1;
        junk_fill = 1'b1;
        s_valid   = 1'b0;
        s_data    = '0;
        m_ready   = 1'b1;
        @(posedge clk); #1;
        junk_fill = 1'b0;
        do_reset();

        for (int v = 0; v < 9; v++) burst(vecs[v].din, vecs[v].exp);

        // Backpressure: hold m_ready low for three edges while tap 1 is presented.
        push(60);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_beat(0, 60);
        @(posedge clk); #1;
        m_ready = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            check_beat(1, 50);
            check("bp_stall", {ram_ce, ram_ad}, {1'b0, 7'(wp - 2)});
            @(posedge clk); #1;
        end
        check_beat(1, 50);
        m_ready = 1'b1;
        #1;
        check("bp_resume", {ram_ce, ram_wre, ram_ad}, {1'b1, 1'b0, 7'(wp - 2)});
        @(posedge clk); #1;
        check_beat(2, 40);
        @(posedge clk); #1;
        check_beat(3, 30);
        @(posedge clk); #1;
        check("bp_ready_return", {s_ready, m_valid}, 2'b10);
        wp = wp + 1'b1;

        // Reset while tap 2 is on the output aborts the burst and restarts the clear.
        push(70);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_beat(0, 70);
        @(posedge clk); #1;
        check_beat(1, 60);
        @(posedge clk); #1;
        check_beat(2, 50);
        reset = 1'b1;
        @(posedge clk); #1;
        check("reset_abort", {m_valid, s_ready, m_tap, m_last}, 10'd0);
        check("reset_clear_start", {ram_ce, ram_wre, ram_ad}, {1'b1, 1'b1, 7'd0});
        reset = 1'b0;
        check_clear();
        e[0] = 77; e[1] = 0; e[2] = 0; e[3] = 0;
        burst(77, e);

        // Wrap-around: 130 samples valued by index from a fresh clear.
        do_reset();
        for (int i = 0; i < 130; i++) begin
            for (int k = 0; k < TAPS; k++) e[k] = (i >= k) ? DW'(i - k) : '0;
            burst(DW'(i), e);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
